// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port to one-port memory arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arbiter.sv).
package mem_arb_pkg;

  // Default address/data width of the unified memory.
  localparam int WORD_SIZE_DEF = 16;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  // Owner of the access in flight.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times how long a memory strobe is held.
// Loads MEM_LATENCY-1 on grant, counts down while enabled, and flags zero
// in the last strobe cycle. It stops at zero instead of wrapping.
module mem_lat_counter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: load wins over decrement; hold at zero.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (load) begin
      count_d = CW'(MEM_LATENCY - 1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule : mem_lat_counter

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the fetch (I) and data (D) ports.
// IDLE grants a requester and latches its access, ACCESS holds the strobe for
// MEM_LATENCY cycles and captures read data, ACK pulses the owner's ack.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN -- on a tie, grant the port
// that was not the last owner; otherwise D always beats I.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy
);

  state_e               state_q,   state_d;
  owner_e               owner_q,   owner_d;
  logic [WORD_SIZE-1:0] addr_q,    addr_d;
  logic                 we_q,      we_d;
  logic [WORD_SIZE-1:0] wdata_q,   wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e               last_owner_q, last_owner_d;
`endif

  owner_e grant_owner;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  mem_lat_counter #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_lat_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .zero   (cnt_zero)
  );

  // Pick which port would win if a grant happened this cycle.
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant_owner = (last_owner_q == OWN_D) ? OWN_I : OWN_D;
    end else begin
      grant_owner = d_req ? OWN_D : OWN_I;
    end
`else
    grant_owner = d_req ? OWN_D : OWN_I;
`endif
  end

  // Next-state logic: grant and latch in IDLE, time the strobe, capture read data.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d  = ACCESS;
          owner_d  = grant_owner;
          addr_d   = (grant_owner == OWN_D) ? d_addr : i_addr;
          we_d     = (grant_owner == OWN_D) && d_we;
          wdata_d  = d_wdata;
          cnt_load = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_owner_d = grant_owner;
`endif
        end
      end
      ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          // Stores leave both read-data registers untouched.
          if (!we_q) begin
            if (owner_q == OWN_D) begin
              d_rdata_d = m_rdata;
            end else begin
              i_rdata_d = m_rdata;
            end
          end
          state_d = ACK;
        end
      end
      ACK: begin
        // Requests are ignored here; a held request is re-arbitrated from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-access registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= OWN_I;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Outputs come only from registers and decoded state: no req-to-strobe path.
  assign m_readM   = (state_q == ACCESS) && !we_q;
  assign m_writeM  = (state_q == ACCESS) &&  we_q;
  assign m_address = addr_q;
  assign m_wdata   = wdata_q;
  assign i_ack     = (state_q == ACK) && (owner_q == OWN_I);
  assign d_ack     = (state_q == ACK) && (owner_q == OWN_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with MEM_LATENCY=2.
// A timeline model (grant cycle T: strobes in T+1..T+L, ack in T+L+1) is
// compared against the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int W = 16;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_req = 1'b0;
  logic [W-1:0] i_addr = '0;
  logic [W-1:0] i_rdata;
  logic         i_ack;
  logic         d_req = 1'b0;
  logic         d_we = 1'b0;
  logic [W-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic [W-1:0] d_rdata;
  logic         d_ack;
  logic         m_readM;
  logic         m_writeM;
  logic [W-1:0] m_address;
  logic [W-1:0] m_wdata;
  logic [W-1:0] m_rdata;
  logic         busy;

  mem_arbiter #(
    .WORD_SIZE  (W),
    .MEM_LATENCY(L)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .m_readM  (m_readM),
    .m_writeM (m_writeM),
    .m_address(m_address),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Power-on memory contents, shared by the memory and the model.
  function automatic logic [W-1:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hBEEF;
      8'h20:   return 16'h5A5A;
      default: return 16'hC3C3 ^ {8'h00, a};
    endcase
  endfunction

  // Memory model driven by the DUT strobes.
  logic [W-1:0] mem [256];
  bit           mem_wr [256];
  assign m_rdata = mem_wr[m_address[7:0]] ? mem[m_address[7:0]] : init_val(m_address[7:0]);

  always @(posedge clk) begin
    if (m_writeM) begin
      mem[m_address[7:0]]    <= m_wdata;
      mem_wr[m_address[7:0]] <= 1'b1;
    end
  end

  function automatic logic [W-1:0] env_rd(input logic [7:0] a);
    return mem_wr[a] ? mem[a] : init_val(a);
  endfunction

  // Reference model: one record per granted transaction on a cycle timeline.
  logic [W-1:0] ref_mem [256];
  bit           ref_wr [256];
  int           cyc = 0;
  int           t_g = -100;
  bit           mo = 1'b0;
  bit           mwe = 1'b0;
  bit           last_d = 1'b0;
  logic [W-1:0] ma = '0;
  logic [W-1:0] mwd = '0;
  logic [W-1:0] exp_ir = '0;
  logic [W-1:0] exp_dr = '0;

  function automatic logic [W-1:0] ref_rd(input logic [7:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_g    <= -100;
      mo     <= 1'b0;
      mwe    <= 1'b0;
      last_d <= 1'b0;
      ma     <= '0;
      mwd    <= '0;
      exp_ir <= '0;
      exp_dr <= '0;
    end else begin
      if (cyc == t_g + L) begin
        if (mwe) begin
          ref_mem[ma[7:0]] <= mwd;
          ref_wr[ma[7:0]]  <= 1'b1;
        end else if (mo) begin
          exp_dr <= ref_rd(ma[7:0]);
        end else begin
          exp_ir <= ref_rd(ma[7:0]);
        end
      end
      if ((cyc >= t_g + L + 2) && (i_req || d_req)) begin : grant
        bit pick;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick = (i_req && d_req) ? ~last_d : d_req;
`else
        pick = d_req;
`endif
        t_g    <= cyc;
        mo     <= pick;
        ma     <= pick ? d_addr : i_addr;
        mwe    <= pick && d_we;
        mwd    <= d_wdata;
        last_d <= pick;
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    int k;
    k = cyc - t_g;
    check("i_ack",     i_ack,     (k == L + 1) && !mo);
    check("d_ack",     d_ack,     (k == L + 1) &&  mo);
    check("m_readM",   m_readM,   (k >= 1) && (k <= L) && !mwe);
    check("m_writeM",  m_writeM,  (k >= 1) && (k <= L) &&  mwe);
    check("busy",      busy,      (k >= 1) && (k <= L + 1));
    check("m_address", m_address, ma);
    check("m_wdata",   m_wdata,   mwd);
    check("i_rdata",   i_rdata,   exp_ir);
    check("d_rdata",   d_rdata,   exp_dr);
  end

  // Running totals of strobe and ack cycles for the directed checks.
  int rd_total = 0;
  int wr_total = 0;
  int dack_total = 0;
  always @(negedge clk) begin
    rd_total   <= rd_total + int'(m_readM);
    wr_total   <= wr_total + int'(m_writeM);
    dack_total <= dack_total + int'(d_ack);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Wait for one port's ack; a missing ack counts as a failed comparison.
  task automatic wait_ack(input string name, input bit is_d, input int budget, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      step(1);
      n++;
      got = is_d ? d_ack : i_ack;
    end
    check({name, "_ack_seen"}, got, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, rd0, wr0, da0, d_at, i_at, nacks;
    bit order [3];

    // Reset state.
    step(2);
    check("rst_busy", busy, 1'b0);
    check("rst_m_address", m_address, 16'h0000);
    check("rst_i_rdata", i_rdata, 16'h0000);
    reset_n = 1'b1;
    step(1);

    // Scenario 1: reset in the middle of a load.
    d_we = 1'b0; d_addr = 16'h0020; d_req = 1'b1;
    da0 = dack_total;
    step(2);
    check("s1_readM_before_reset", m_readM, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("s1_readM_async_drop", m_readM, 1'b0);
    check("s1_busy_async_drop", busy, 1'b0);
    d_req = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(4);
    check("s1_no_d_ack", dack_total - da0, 0);
    check("s1_d_rdata_cleared", d_rdata, 16'h0000);

    // Scenario 2: fetch, address change mid-access is ignored.
    rd0 = rd_total;
    i_addr = 16'h0010; i_req = 1'b1;
    step(1);
    i_addr = 16'h0077;
    wait_ack("s2", 1'b0, 10, n);
    i_req = 1'b0;
    check("s2_latency", n + 1, L + 1);
    check("s2_i_rdata", i_rdata, 16'hBEEF);
    check("s2_m_address", m_address, 16'h0010);
    check("s2_read_cycles", rd_total - rd0, 2);
    step(1);

    // Scenario 3: a load to give d_rdata a value, then a store.
    d_we = 1'b0; d_addr = 16'h0020; d_req = 1'b1;
    wait_ack("s3_load", 1'b1, 10, n);
    d_req = 1'b0;
    check("s3_d_rdata_load", d_rdata, 16'h5A5A);
    step(1);
    rd0 = rd_total; wr0 = wr_total;
    d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234; d_req = 1'b1;
    wait_ack("s3_store", 1'b1, 10, n);
    d_req = 1'b0; d_we = 1'b0;
    check("s3_write_cycles", wr_total - wr0, 2);
    check("s3_read_cycles", rd_total - rd0, 0);
    check("s3_d_rdata_kept", d_rdata, 16'h5A5A);
    check("s3_m_wdata", m_wdata, 16'h1234);
    step(1);
    check("s3_mem_written", env_rd(8'h40), 16'h1234);
    i_addr = 16'h0040; i_req = 1'b1;
    wait_ack("s3_fetch_back", 1'b0, 10, n);
    i_req = 1'b0;
    check("s3_fetch_back_data", i_rdata, 16'h1234);
    step(1);

    // Scenario 4a: simultaneous requests, each dropped after its ack.
    i_addr = 16'h0010; d_addr = 16'h0030; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    d_at = -1; i_at = -1; n = 0;
    while ((d_at < 0 || i_at < 0) && n < 20) begin
      step(1);
      n++;
      if (d_ack) begin d_at = n; d_req = 1'b0; end
      if (i_ack) begin i_at = n; i_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("s4a_d_first", (d_at >= 0) && (i_at > d_at), 1'b1);
    check("s4a_ack_gap", i_at - d_at, L + 2);
    check("s4a_d_rdata", d_rdata, 16'hC3F3);
    step(1);

    // Scenario 4b: both requests held across three grants.
    i_req = 1'b1; d_req = 1'b1;
    nacks = 0; n = 0;
    while (nacks < 3 && n < 30) begin
      step(1);
      n++;
      if (d_ack || i_ack) begin
        order[nacks] = d_ack;
        nacks++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("s4b_ack_count", nacks, 3);
    check("s4b_first_is_d", order[0], 1'b1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    check("s4b_second", order[1], 1'b0);
`else
    check("s4b_second", order[1], 1'b1);
`endif
    check("s4b_third", order[2], 1'b1);
    step(1);

    // Scenario 5: data request dropped one cycle after the grant.
    d_we = 1'b0; d_addr = 16'h0030; d_req = 1'b1;
    step(1);
    d_req = 1'b0;
    wait_ack("s5", 1'b1, 10, n);
    check("s5_latency", n + 1, L + 1);
    check("s5_d_rdata", d_rdata, 16'hC3F3);
    step(1);
    check("s5_idle_after", busy, 1'b0);
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mem_arbiter
